// File: rtl/uart_echo_buffered.sv
// Buffered UART echo: RX bytes go through a DEPTH-entry FIFO and are replayed to TX with an optional case transform.
// Define ECHO_CRLF_EN to follow every transmitted CR_CHAR with an automatic LF_CHAR.
//   state     | meaning
//   IDLE      | pop the FIFO head when not empty; mode 11 discards it
//   SEND      | one-cycle o_tx_dv request for the loaded byte
//   WAIT_DONE | wait for i_tx_done from the transmitter
//   SEND_LF   | one-cycle request for the appended LF (ECHO_CRLF_EN only)
module uart_echo_buffered #(
   parameter int unsigned DEPTH   = 16,
   parameter logic [7:0]  CR_CHAR = 8'h0D,
   parameter logic [7:0]  LF_CHAR = 8'h0A
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_rx_dv,
   input  logic [7:0]               i_rx_byte,
   input  logic                     i_tx_done,
   input  logic [1:0]               i_mode,
   input  logic                     i_clr_ovf,
   output logic                     o_tx_dv,
   output logic [7:0]               o_tx_byte,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, SEND_LF} state_t;

   state_t         state, state_n;
   logic [7:0]     mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           rx_dv_q;
   logic           overflow;
   logic           tx_dv, tx_dv_n;
   logic [7:0]     tx_byte, tx_byte_n;
   logic           pop;
   logic           full, empty;
   logic           wr_req, wr_acc, drop;
`ifdef ECHO_CRLF_EN
   logic           lf_q, lf_n;
`endif

   function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] m);
      logic [7:0] r;
      r = b;
      if (m == 2'b01 && b >= 8'h61 && b <= 8'h7A)
         r = b - 8'h20;
      else if (m == 2'b10 && b >= 8'h41 && b <= 8'h5A)
         r = b + 8'h20;
      return r;
   endfunction

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign wr_req = i_rx_dv & ~rx_dv_q;
   // A pop in the same cycle frees the slot, so a write while full is still accepted then.
   assign wr_acc = wr_req & (~full | pop);
   assign drop   = wr_req & full & ~pop;

   always_comb begin
      state_n   = state;
      pop       = 1'b0;
      tx_dv_n   = 1'b0;
      tx_byte_n = tx_byte;
`ifdef ECHO_CRLF_EN
      lf_n      = lf_q;
`endif
      case (state)
         IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (i_mode != 2'b11) begin
                  tx_byte_n = xform(mem[rd_ptr], i_mode);
                  state_n   = SEND;
               end
            end
         end
         SEND: begin
            tx_dv_n = 1'b1;
            state_n = WAIT_DONE;
`ifdef ECHO_CRLF_EN
            lf_n    = 1'b0;
`endif
         end
         WAIT_DONE: begin
            if (i_tx_done) begin
`ifdef ECHO_CRLF_EN
               if (tx_byte == CR_CHAR && !lf_q) begin
                  tx_byte_n = LF_CHAR;
                  state_n   = SEND_LF;
               end else begin
                  state_n   = IDLE;
               end
`else
               state_n = IDLE;
`endif
            end
         end
`ifdef ECHO_CRLF_EN
         SEND_LF: begin
            tx_dv_n = 1'b1;
            lf_n    = 1'b1;
            state_n = WAIT_DONE;
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         rx_dv_q  <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         tx_dv    <= 1'b0;
         tx_byte  <= 8'h00;
`ifdef ECHO_CRLF_EN
         lf_q     <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         rx_dv_q <= i_rx_dv;
         tx_dv   <= tx_dv_n;
         tx_byte <= tx_byte_n;
`ifdef ECHO_CRLF_EN
         lf_q    <= lf_n;
`endif
         if (wr_acc)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr_acc, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop)
            overflow <= 1'b1;
         else if (i_clr_ovf)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_acc)
         mem[wr_ptr] <= i_rx_byte;
   end

   assign o_tx_dv    = tx_dv;
   assign o_tx_byte  = tx_byte;
   assign o_count    = count;
   assign o_full     = full;
   assign o_empty    = empty;
   assign o_overflow = overflow;

endmodule

// File: tb/tb_uart_echo_buffered.sv
// Directed self-checking bench for uart_echo_buffered, built with DEPTH=4 and ECHO_CRLF_EN undefined.
module tb_uart_echo_buffered;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_rx_dv = 1'b0;
   logic [7:0] i_rx_byte = 8'h00;
   logic       i_tx_done = 1'b0;
   logic [1:0] i_mode = 2'b00;
   logic       i_clr_ovf = 1'b0;
   logic       o_tx_dv;
   logic [7:0] o_tx_byte;
   logic [2:0] o_count;
   logic       o_full;
   logic       o_empty;
   logic       o_overflow;

   int checks = 0;
   int errors = 0;
   logic [7:0] txq[$];

   uart_echo_buffered #(.DEPTH(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
      .i_tx_done(i_tx_done), .i_mode(i_mode), .i_clr_ovf(i_clr_ovf),
      .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte), .o_count(o_count),
      .o_full(o_full), .o_empty(o_empty), .o_overflow(o_overflow)
   );

   always #5 i_clk = ~i_clk;

   // Every TX request seen at mid-cycle is logged with its byte.
   always @(negedge i_clk)
      if (o_tx_dv === 1'b1) txq.push_back(o_tx_byte);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_byte = b;
      i_rx_dv = 1'b1;
      tick;
      i_rx_dv = 1'b0;
      tick;
   endtask

   task automatic done_pulse;
      i_tx_done = 1'b1;
      tick;
      i_tx_done = 1'b0;
   endtask

   task automatic wait_req(input int target, input int budget);
      int n;
      n = 0;
      while (txq.size() < target && n < budget) begin
         tick;
         n++;
      end
      check("req_seen", 32'(txq.size() >= target), 32'd1);
   endtask

   task automatic ack_n(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         wait_req(base + i + 1, 100);
         repeat (19) tick;
         done_pulse;
      end
   endtask

   initial begin
      int base;
      int pk;
      int n;

      // reset
      tick; tick;
      check("rst_tx_dv", o_tx_dv, 0);
      check("rst_tx_byte", o_tx_byte, 8'h00);
      check("rst_count", o_count, 0);
      check("rst_full", o_full, 0);
      check("rst_empty", o_empty, 1);
      check("rst_ovf", o_overflow, 0);
      i_rst_n = 1'b1;
      tick;

      // T1: latency of a single byte
      base = txq.size();
      i_rx_byte = 8'h61; i_rx_dv = 1'b1;
      tick;
      check("t1_count_wr", o_count, 1);
      check("t1_dv_k", o_tx_dv, 0);
      i_rx_dv = 1'b0;
      tick;
      check("t1_count_pop", o_count, 0);
      check("t1_dv_k1", o_tx_dv, 0);
      tick;
      check("t1_dv_k2", o_tx_dv, 1);
      check("t1_byte", o_tx_byte, 8'h61);
      tick;
      check("t1_dv_once", o_tx_dv, 0);
      repeat (5) tick;
      done_pulse;
      repeat (5) tick;
      check("t1_byte_held", o_tx_byte, 8'h61);
      check("t1_nreq", txq.size() - base, 1);

      // T2: upper-case transform
      base = txq.size();
      i_mode = 2'b01;
      send_byte(8'h61); send_byte(8'h62); send_byte(8'h5A);
      ack_n(3, base);
      repeat (5) tick;
      check("t2_nreq", txq.size() - base, 3);
      check("t2_b0", txq[base], 8'h41);
      check("t2_b1", txq[base+1], 8'h42);
      check("t2_b2", txq[base+2], 8'h5A);
      check("t2_empty", o_empty, 1);

      // lower-case transform
      base = txq.size();
      i_mode = 2'b10;
      send_byte(8'h51); send_byte(8'h35); send_byte(8'h7A);
      ack_n(3, base);
      repeat (5) tick;
      check("lc_b0", txq[base], 8'h71);
      check("lc_b1", txq[base+1], 8'h35);
      check("lc_b2", txq[base+2], 8'h7A);

      // T3: overflow with transmitter stalled on a blocker byte
      i_mode = 2'b00;
      base = txq.size();
      send_byte(8'hA0);
      wait_req(base + 1, 50);
      for (int i = 0; i < 6; i++) send_byte(8'hB1 + 8'(i));
      check("t3_count", o_count, 4);
      check("t3_full", o_full, 1);
      check("t3_ovf", o_overflow, 1);
      i_clr_ovf = 1'b1; i_rx_byte = 8'hB7; i_rx_dv = 1'b1;
      tick;
      check("t3_drop_beats_clr", o_overflow, 1);
      i_rx_dv = 1'b0; i_clr_ovf = 1'b0;
      tick;
      check("t3_count_hold", o_count, 4);
      done_pulse;
      ack_n(4, base + 1);
      repeat (20) tick;
      check("t3_nreq", txq.size() - base, 5);
      check("t3_b0", txq[base+1], 8'hB1);
      check("t3_b3", txq[base+4], 8'hB4);
      check("t3_empty", o_empty, 1);
      check("t3_ovf_sticky", o_overflow, 1);
      i_clr_ovf = 1'b1;
      tick;
      i_clr_ovf = 1'b0;
      check("t3_ovf_clr", o_overflow, 0);

      // T4: long rx_dv gives exactly one write
      base = txq.size();
      pk = 0;
      i_rx_byte = 8'h33; i_rx_dv = 1'b1;
      repeat (5) begin
         tick;
         if (int'(o_count) > pk) pk = int'(o_count);
      end
      i_rx_dv = 1'b0;
      tick;
      check("t4_peak", pk, 1);
      ack_n(1, base);
      repeat (20) tick;
      check("t4_nreq", txq.size() - base, 1);
      check("t4_byte", txq[base], 8'h33);

      // T5: CR passes alone when CRLF expansion is not built in
      base = txq.size();
      send_byte(8'h0D);
      ack_n(1, base);
      repeat (20) tick;
      check("t5_nreq", txq.size() - base, 1);
      check("t5_byte", txq[base], 8'h0D);

      // T6: reset during WAIT_DONE
      base = txq.size();
      send_byte(8'hC1);
      wait_req(base + 1, 50);
      send_byte(8'hC2); send_byte(8'hC3);
      check("t6_count_pre", o_count, 2);
      i_rst_n = 1'b0;
      tick;
      check("t6_tx_dv", o_tx_dv, 0);
      check("t6_tx_byte", o_tx_byte, 8'h00);
      check("t6_count", o_count, 0);
      check("t6_full", o_full, 0);
      check("t6_empty", o_empty, 1);
      check("t6_ovf", o_overflow, 0);
      i_rst_n = 1'b1;
      tick;
      done_pulse;
      repeat (10) tick;
      check("t6_nreq", txq.size() - base, 1);
      check("t6_count_post", o_count, 0);

      // T7: discard mode
      base = txq.size();
      i_mode = 2'b11;
      send_byte(8'hD1); send_byte(8'hD2);
      n = 0;
      while (o_count != 0 && n < 4) begin
         tick;
         n++;
      end
      check("t7_count", o_count, 0);
      repeat (10) tick;
      check("t7_nreq", txq.size() - base, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
